display_scan_scheduler: RTL and testbench

Sequences the 4-digit 7-segment multiplex for the reaction timer display.
- Generates the 2-bit digit-slot select consumed by the cathode/digit mux, plus the active-low anode enables.
- Inserts an anti-ghosting blank gap at the start of every slot.
- Accepts new BCD values through a valid/ready handshake and commits them only at frame boundaries, so a displayed frame never tears.

---
 rtl/display_pkg.sv | 13 +
 rtl/scan_prescaler.sv | 57 +++++
 rtl/display_scan_scheduler.sv | 94 +++++++++
 tb/tb_display_scan_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display path.
package display_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [1:0] SLOT_THOU = 2'd0;
  localparam logic [1:0] SLOT_HUND = 2'd1;
  localparam logic [1:0] SLOT_TEN  = 2'd2;
  localparam logic [1:0] SLOT_UNIT = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: divides clk into REFRESH_DIV-cycle slots and flags the blank gap.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned DIV_W        = $clog2(REFRESH_DIV)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  output logic [1:0] slot_o,
  output logic       frame_tick_o,
  output logic       in_blank_o
);

  localparam logic [DIV_W-1:0] CntMax   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BlankLim = DIV_W'(BLANK_CYCLES);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic             slot_end;

  assign slot_end = (div_cnt_q == CntMax);

  always_comb begin
    div_cnt_d = div_cnt_q;
    slot_d    = slot_q;
    if (!enable_i) begin
      // Halted scan always restarts from the first slot's blank gap.
      div_cnt_d = '0;
      slot_d    = SLOT_THOU;
    end else if (slot_end) begin
      div_cnt_d = '0;
      slot_d    = slot_q + 2'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      slot_q    <= SLOT_THOU;
    end else begin
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
    end
  end

  always_comb begin
    slot_o       = slot_q;
    frame_tick_o = enable_i && (slot_q == SLOT_UNIT) && slot_end;
    in_blank_o   = (div_cnt_q < BlankLim);
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Display scan scheduler: slot sequencing, anode decode and frame-synchronous digit update.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned DIV_W        = $clog2(REFRESH_DIV)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               lz_blank,
  input  logic               upd_valid,
  input  logic [4*BCD_W-1:0] upd_bcd,
  output logic               upd_ready,
  output logic [BCD_W-1:0]   thousand,
  output logic [BCD_W-1:0]   hund,
  output logic [BCD_W-1:0]   ten,
  output logic [BCD_W-1:0]   unit,
  output logic [1:0]         anode_sel,
  output logic [3:0]         an_n,
  output logic               frame_tick
);

  logic [1:0] slot;
  logic       scan_tick;
  logic       in_blank;

  scan_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .DIV_W        (DIV_W)
  ) u_prescaler (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .slot_o       (slot),
    .frame_tick_o (scan_tick),
    .in_blank_o   (in_blank)
  );

  logic [4*BCD_W-1:0] shadow_q, shadow_d;
  logic [4*BCD_W-1:0] display_q, display_d;
  logic               pending_q, pending_d;
  logic               accept;
  logic               commit;
  logic               lead_zero;

  assign accept = upd_valid && upd_ready;
  // A dark display cannot tear, so disabling commits immediately.
  assign commit = pending_q && (scan_tick || !enable);

  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    if (commit) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = upd_bcd;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
    end
  end

  assign lead_zero = lz_blank && (slot == SLOT_THOU) &&
                     (display_q[4*BCD_W-1 -: BCD_W] == '0);

  // Outputs are forced quiet combinationally while reset is asserted.
  always_comb begin
    upd_ready  = rst_n && !pending_q;
    frame_tick = rst_n && scan_tick;
    anode_sel  = rst_n ? slot : SLOT_THOU;
    {thousand, hund, ten, unit} = rst_n ? display_q : '0;
    an_n = AN_OFF;
    if (rst_n && enable && !in_blank && !lead_zero) begin
      an_n = ~(4'b1000 >> slot);
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Self-checking bench: cycle model feeds an expected-output queue; accepted data feeds a commit queue.
module tb_display_scan_scheduler;

  localparam int unsigned RefreshDiv  = 8;
  localparam int unsigned BlankCycles = 2;
  localparam int          FrameLen    = 4 * RefreshDiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        lz_blank;
  logic        upd_valid;
  logic [15:0] upd_bcd;
  logic        upd_ready;
  logic [3:0]  thousand, hund, ten, unit;
  logic [1:0]  anode_sel;
  logic [3:0]  an_n;
  logic        frame_tick;

  always #5 clk = ~clk;

  display_scan_scheduler #(
    .REFRESH_DIV  (RefreshDiv),
    .BLANK_CYCLES (BlankCycles)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .upd_valid  (upd_valid),
    .upd_bcd    (upd_bcd),
    .upd_ready  (upd_ready),
    .thousand   (thousand),
    .hund       (hund),
    .ten        (ten),
    .unit       (unit),
    .anode_sel  (anode_sel),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0]  an;
    logic [1:0]  sel;
    logic [15:0] dig;
    logic        rdy;
    logic        tick;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] data_q[$];

  int          checks = 0;
  int          errors = 0;

  // Reference model state
  int          m_cnt = 0;
  int          m_slot = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_disp = '0;
  logic        m_pend = 1'b0;

  logic [3:0]  lit_tbl [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [15:0] last_disp = '0;
  bit          acc_seen;
  int          cyc = 0;
  int          last_tick = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    exp_t        e;
    exp_t        p;
    logic [15:0] cur;
    bit          acc;
    bit          tk;
    @(negedge clk);
    e.tick = rst_n && enable && (m_slot == 3) && (m_cnt == RefreshDiv - 1);
    e.rdy  = rst_n && !m_pend;
    e.sel  = rst_n ? 2'(m_slot) : 2'd0;
    e.dig  = rst_n ? m_disp : 16'h0;
    e.an   = 4'b1111;
    if (rst_n && enable && (m_cnt >= BlankCycles) &&
        !(lz_blank && (m_slot == 0) && (m_disp[15:12] == 4'h0)))
      e.an = lit_tbl[m_slot];
    exp_q.push_back(e);

    p = exp_q.pop_front();
    check_eq("an_n", 32'(an_n), 32'(p.an));
    check_eq("anode_sel", 32'(anode_sel), 32'(p.sel));
    check_eq("digits", 32'({thousand, hund, ten, unit}), 32'(p.dig));
    check_eq("upd_ready", 32'(upd_ready), 32'(p.rdy));
    check_eq("frame_tick", 32'(frame_tick), 32'(p.tick));

    acc_seen = 1'b0;
    if (rst_n && upd_valid && upd_ready) begin
      data_q.push_back(upd_bcd);
      acc_seen = 1'b1;
    end

    cur = {thousand, hund, ten, unit};
    if (cur != last_disp) begin
      if (data_q.size() == 0) check_eq("commit_spurious", 32'(cur), 32'(last_disp));
      else check_eq("commit_data", 32'(cur), 32'(data_q.pop_front()));
      last_disp = cur;
    end

    if (!enable || !rst_n) last_tick = -1;
    else if (frame_tick === 1'b1) begin
      if (last_tick >= 0) check_eq("tick_period", 32'(cyc - last_tick), 32'(FrameLen));
      last_tick = cyc;
    end

    if (!rst_n) begin
      m_cnt = 0; m_slot = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
    end else begin
      acc = upd_valid && !m_pend;
      tk  = enable && (m_slot == 3) && (m_cnt == RefreshDiv - 1);
      if (m_pend && (tk || !enable)) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (acc) begin
        m_shadow = upd_bcd;
        m_pend   = 1'b1;
      end
      if (!enable) begin
        m_cnt = 0; m_slot = 0;
      end else if (m_cnt == RefreshDiv - 1) begin
        m_cnt = 0; m_slot = (m_slot + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int s, input int c);
    int n = 0;
    while (!(m_slot == s && m_cnt == c) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check_eq("wait_timeout", 32'(n), 32'd0);
  endtask

  task automatic offer(input logic [15:0] v);
    int n = 0;
    upd_valid = 1'b1;
    upd_bcd   = v;
    do begin
      step();
      n++;
    end while (!acc_seen && n < 100);
    if (!acc_seen) check_eq("offer_timeout", 32'(n), 32'd0);
    upd_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    lz_blank  = 1'b0;
    upd_valid = 1'b1;
    upd_bcd   = 16'hdead;
    @(posedge clk);
    #1;

    // Reset with a value offered: nothing may be captured
    run(3);
    rst_n     = 1'b1;
    upd_valid = 1'b0;
    #1;
    check_eq("ready_after_reset", 32'(upd_ready), 32'd1);

    // Free-running scan over two frames
    run(2 * FrameLen);

    // Mid-slot-1 update, then a second value held under backpressure
    wait_pos(1, 3);
    offer(16'h1234);
    check_eq("ready_pending", 32'(upd_ready), 32'd0);
    check_eq("digits_hold", 32'({thousand, hund, ten, unit}), 32'h0);
    offer(16'h5678);
    check_eq("bp_after_commit", 32'({thousand, hund, ten, unit}), 32'h1234);

    // Accept landing on the frame_tick cycle waits one full frame
    wait_pos(3, RefreshDiv - 1);
    step();
    check_eq("second_commit", 32'({thousand, hund, ten, unit}), 32'h5678);
    wait_pos(3, RefreshDiv - 1);
    offer(16'h2468);
    check_eq("tick_accept_hold", 32'({thousand, hund, ten, unit}), 32'h5678);
    wait_pos(3, RefreshDiv - 1);
    step();
    check_eq("tick_accept_commit", 32'({thousand, hund, ten, unit}), 32'h2468);

    // Leading-zero blanking
    lz_blank = 1'b1;
    offer(16'h0456);
    wait_pos(3, RefreshDiv - 1);
    step();
    wait_pos(0, 5);
    check_eq("lz_dark", 32'(an_n), 32'hf);
    run(FrameLen);
    offer(16'h1456);
    wait_pos(3, RefreshDiv - 1);
    step();
    wait_pos(0, 5);
    check_eq("lz_lit", 32'(an_n), 32'h7);
    run(FrameLen);

    // Disable mid-frame with a value pending
    lz_blank = 1'b0;
    wait_pos(0, 1);
    offer(16'h0789);
    wait_pos(2, 4);
    enable = 1'b0;
    #1;
    check_eq("dark_now", 32'(an_n), 32'hf);
    step();
    check_eq("dark_sel", 32'(anode_sel), 32'd0);
    check_eq("dark_commit", 32'({thousand, hund, ten, unit}), 32'h0789);
    run(3);
    enable = 1'b1;
    #1;
    check_eq("reenable_blank", 32'(an_n), 32'hf);
    run(BlankCycles);
    check_eq("reenable_lit", 32'(an_n), 32'h7);
    run(FrameLen + 8);

    check_eq("data_q_empty", 32'(data_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
